// File: rtl/csr_machine_unit.sv
// Machine-mode CSR unit: CSR read/modify/write, mcycle counter, interrupt entry and mret.
// Build option: define CSR_VECTORED_EN to allow mtvec vectored mode (MODE=1).

module csr_machine_unit #(
    parameter int              XLEN          = 32,
    parameter int              NUM_LOCAL_IRQ = 0,
    parameter int              CYCLE_W       = 64,
    parameter logic [XLEN-1:0] RESET_VEC     = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [11:0]           csr_addr,
    input  logic [1:0]            csr_op,
    input  logic [XLEN-1:0]       csr_wdata,
    output logic [XLEN-1:0]       csr_rdata,
    output logic                  csr_illegal,
    input  logic [XLEN-1:0]       pc,
    input  logic                  instr_valid,
    input  logic                  mret,
    input  logic                  ext_irq,
    input  logic                  tmr_irq,
    input  logic                  sw_irq,
    input  logic [(NUM_LOCAL_IRQ > 0 ? NUM_LOCAL_IRQ : 1)-1:0] local_irq,
    output logic                  irq_pending,
    output logic                  trap_taken,
    output logic [XLEN-1:0]       trap_pc,
    output logic [XLEN-1:0]       epc
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;

    function automatic logic [XLEN-1:0] mie_mask_f();
        logic [XLEN-1:0] m;
        m     = '0;
        m[3]  = 1'b1;
        m[7]  = 1'b1;
        m[11] = 1'b1;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) m[16+i] = 1'b1;
        return m;
    endfunction

    localparam logic [XLEN-1:0] MIE_MASK = mie_mask_f();
`ifdef CSR_VECTORED_EN
    localparam logic [XLEN-1:0] MTVEC_RST = {RESET_VEC[XLEN-1:2], 1'b0, RESET_VEC[0]};
`else
    localparam logic [XLEN-1:0] MTVEC_RST = {RESET_VEC[XLEN-1:2], 2'b00};
`endif

    typedef enum logic {ST_RUN, ST_TRAP} state_e;

    state_e               state_q, state_d;
    logic                 mstatus_mie_q, mstatus_mie_d;
    logic                 mstatus_mpie_q, mstatus_mpie_d;
    logic [XLEN-1:0]      mie_q, mie_d;
    logic [XLEN-1:0]      mtvec_q, mtvec_d;
    logic [XLEN-1:0]      mscratch_q, mscratch_d;
    logic [XLEN-1:0]      mepc_q, mepc_d;
    logic [XLEN-1:0]      mcause_q, mcause_d;
    logic [CYCLE_W-1:0]   mcycle_q, mcycle_d;
    logic                 trap_taken_q, trap_taken_d;
    logic [XLEN-1:0]      trap_pc_q, trap_pc_d;

    logic [63:0]          cyc64;
    logic [XLEN-1:0]      mip, irq_pend, mstatus_rd, rdata, wval, trap_tgt;
    logic [4:0]           irq_code;
    logic                 addr_hit, take_trap, do_write, do_mret;
    logic                 unused_local;

    assign cyc64        = 64'(mcycle_q);
    assign unused_local = ^local_irq;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        mip     = '0;
        mip[3]  = sw_irq;
        mip[7]  = tmr_irq;
        mip[11] = ext_irq;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) mip[16+i] = local_irq[i];

        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mstatus_mpie_q;
        mstatus_rd[3]     = mstatus_mie_q;
    end

    always_comb begin
        rdata    = '0;
        addr_hit = 1'b1;
        case (csr_addr)
            A_MSTATUS:  rdata = mstatus_rd;
            A_MIE:      rdata = mie_q;
            A_MTVEC:    rdata = mtvec_q;
            A_MSCRATCH: rdata = mscratch_q;
            A_MEPC:     rdata = mepc_q;
            A_MCAUSE:   rdata = mcause_q;
            A_MIP:      rdata = mip;
            A_MCYCLE:   rdata = XLEN'(cyc64);
            A_MCYCLEH: begin
                if (XLEN == 32) rdata = XLEN'(cyc64[63:32]);
                else            addr_hit = 1'b0;
            end
            default:    addr_hit = 1'b0;
        endcase
    end

    assign csr_rdata   = rdata;
    assign csr_illegal = (csr_op != 2'b00) && !addr_hit;
    assign irq_pend    = mip & mie_q;
    assign irq_pending = (|irq_pend) && mstatus_mie_q;
    assign epc         = mepc_q;
    assign trap_taken  = trap_taken_q;
    assign trap_pc     = trap_pc_q;

    // Later assignments win, so the highest-priority source is tested last.
    always_comb begin
        irq_code = 5'd0;
        for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
            if (irq_pend[16+i]) irq_code = 5'(16 + i);
        end
        if (irq_pend[7])  irq_code = 5'd7;
        if (irq_pend[3])  irq_code = 5'd3;
        if (irq_pend[11]) irq_code = 5'd11;
    end

    always_comb begin
        trap_tgt = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef CSR_VECTORED_EN
        if (mtvec_q[1:0] == 2'b01) trap_tgt = {mtvec_q[XLEN-1:2], 2'b00} + XLEN'({irq_code, 2'b00});
`endif
    end

    always_comb begin
        unique case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = rdata | csr_wdata;
            2'b11:   wval = rdata & ~csr_wdata;
            default: wval = rdata;
        endcase
    end

    assign take_trap = (state_q == ST_RUN) && instr_valid && irq_pending;
    assign do_write  = (state_q == ST_RUN) && (csr_op != 2'b00) && !csr_illegal && !take_trap;
    assign do_mret   = (state_q == ST_RUN) && instr_valid && mret && !take_trap;

    always_comb begin
        state_d        = state_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mcycle_d       = mcycle_q + 1'b1;
        trap_taken_d   = 1'b0;
        trap_pc_d      = trap_pc_q;

        if (do_write) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mstatus_mie_d  = wval[3];
                    mstatus_mpie_d = wval[7];
                end
                A_MIE:      mie_d = wval & MIE_MASK;
`ifdef CSR_VECTORED_EN
                A_MTVEC:    mtvec_d = {wval[XLEN-1:2], wval[1] ? mtvec_q[1:0] : wval[1:0]};
`else
                A_MTVEC:    mtvec_d = {wval[XLEN-1:2], 2'b00};
`endif
                A_MSCRATCH: mscratch_d = wval;
                A_MEPC:     mepc_d = {wval[XLEN-1:2], 2'b00};
                A_MCAUSE:   mcause_d = wval;
                A_MCYCLE: begin
                    if (XLEN == 32) mcycle_d = CYCLE_W'({cyc64[63:32], 32'(wval)});
                    else            mcycle_d = CYCLE_W'(wval);
                end
                A_MCYCLEH:  mcycle_d = CYCLE_W'({32'(wval), cyc64[31:0]});
                default: ;
            endcase
        end

        if (do_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end

        if (take_trap) begin
            state_d          = ST_TRAP;
            mepc_d           = {pc[XLEN-1:2], 2'b00};
            mcause_d         = XLEN'(irq_code);
            mcause_d[XLEN-1] = 1'b1;
            mstatus_mpie_d   = mstatus_mie_q;
            mstatus_mie_d    = 1'b0;
            trap_taken_d     = 1'b1;
            trap_pc_d        = trap_tgt;
        end else if (state_q == ST_TRAP) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q        <= ST_RUN;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RST;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mcycle_q       <= '0;
            trap_taken_q   <= 1'b0;
            trap_pc_q      <= '0;
        end else begin
            state_q        <= state_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            trap_taken_q   <= trap_taken_d;
            trap_pc_q      <= trap_pc_d;
        end
    end

endmodule
